// File: rtl/music_box_sequencer.sv
// -----------------------------------------------------------------------------
// music_box_sequencer
//
// Plays a stored melody through a square-wave tone generator. Note entries
// (beats + tone period) are fetched one at a time from an external synchronous
// song ROM. Each note is armed with a phase-resync pulse, held for its
// programmed number of beats, then followed by a fixed silent gap.
//
// Ports
//   clock       sole clock, rising edge
//   reset       asynchronous, active-low reset
//   start       level; begins playback from entry 0 when seen in IDLE
//   stop        level; aborts playback from any busy state, beats start
//   loop_en     at end of song, restart at entry 0 instead of finishing
//   rom_addr    song ROM address
//   rom_data    ROM word: [35:32] beats (0 = end marker), [31:0] period (0 = rest)
//   hz          period to the tone generator
//   play_note   tone enable
//   note_reset  one-cycle phase-resync pulse, high only during ARM
//   busy        high in every state except IDLE
//   done        one-cycle pulse on natural song completion
//   state_dbg   current FSM state encoding, for observation only
//
// ROM protocol: there is no valid/ready handshake. The ROM is a fixed
// one-cycle-latency memory, so rom_data reflects rom_addr one cycle after the
// address changes. FETCH exists purely to absorb that latency; DECODE is the
// only state that samples rom_data.
// -----------------------------------------------------------------------------
module music_box_sequencer #(
    parameter int SONG_LEN       = 16,
    parameter int ADDR_W         = 4,
    parameter int TICKS_PER_BEAT = 12500000,
    parameter int GAP_TICKS      = 500000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [35:0]       rom_data,
    output logic [31:0]       hz,
    output logic              play_note,
    output logic              note_reset,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    // +1 so a parameter value of 1 still yields a non-zero width.
    localparam int TICK_W = $clog2(TICKS_PER_BEAT + 1);
    localparam int GAP_W  = $clog2(GAP_TICKS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ARM    = 3'd3,
        S_PLAY   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   rom_addr_n;
    logic [31:0]         hz_n;
    logic                play_note_n;
    logic                note_reset_n;
    logic                busy_n;
    logic                done_n;
    logic [3:0]          beat_cnt, beat_cnt_n;
    logic [TICK_W-1:0]   tick_cnt, tick_cnt_n;
    logic [GAP_W-1:0]    gap_cnt, gap_cnt_n;

    logic [3:0]          rom_beats;
    logic [31:0]         rom_period;

    assign rom_beats  = rom_data[35:32];
    assign rom_period = rom_data[31:0];
    assign state_dbg  = state;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            rom_addr   <= '0;
            hz         <= '0;
            play_note  <= 1'b0;
            note_reset <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            beat_cnt   <= '0;
            tick_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            state      <= state_n;
            rom_addr   <= rom_addr_n;
            hz         <= hz_n;
            play_note  <= play_note_n;
            note_reset <= note_reset_n;
            busy       <= busy_n;
            done       <= done_n;
            beat_cnt   <= beat_cnt_n;
            tick_cnt   <= tick_cnt_n;
            gap_cnt    <= gap_cnt_n;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n      = state;
        rom_addr_n   = rom_addr;
        hz_n         = hz;
        play_note_n  = play_note;
        note_reset_n = 1'b0;   // pulse outputs default low every cycle
        done_n       = 1'b0;
        beat_cnt_n   = beat_cnt;
        tick_cnt_n   = tick_cnt;
        gap_cnt_n    = gap_cnt;

        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    rom_addr_n = '0;
                    state_n    = S_FETCH;
                end
            end

            S_FETCH: begin
                state_n = S_DECODE;
            end

            S_DECODE: begin
                if (rom_beats == 4'd0) begin
                    // End-of-song marker.
                    if (loop_en) begin
                        rom_addr_n = '0;
                        state_n    = S_FETCH;
                    end else begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end
                end else begin
                    beat_cnt_n   = rom_beats;
                    tick_cnt_n   = '0;
                    hz_n         = rom_period;
                    // Rests leave the generator phase alone.
                    note_reset_n = (rom_period != 32'd0);
                    state_n      = S_ARM;
                end
            end

            S_ARM: begin
                // hz was loaded in DECODE, so a rest keeps the tone disabled.
                play_note_n = (hz != 32'd0);
                state_n     = S_PLAY;
            end

            S_PLAY: begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt_n = '0;
                    beat_cnt_n = beat_cnt - 4'd1;
                    if (beat_cnt == 4'd1) begin
                        play_note_n = 1'b0;
                        gap_cnt_n   = '0;
                        state_n     = S_GAP;
                    end
                end else begin
                    tick_cnt_n = tick_cnt + TICK_W'(1);
                end
            end

            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (rom_addr == ADDR_LAST) begin
                        // Last ROM entry played without a marker: same
                        // end-of-song rule as an explicit marker.
                        if (loop_en) begin
                            rom_addr_n = '0;
                            state_n    = S_FETCH;
                        end else begin
                            done_n  = 1'b1;
                            state_n = S_IDLE;
                        end
                    end else begin
                        rom_addr_n = rom_addr + ADDR_W'(1);
                        state_n    = S_FETCH;
                    end
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Abort overrides everything decided above. hz and rom_addr are
        // deliberately left holding their last values.
        if (stop && (state != S_IDLE)) begin
            state_n      = S_IDLE;
            play_note_n  = 1'b0;
            note_reset_n = 1'b0;
            done_n       = 1'b0;
        end

        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_music_box_sequencer.sv
// -----------------------------------------------------------------------------
// tb_music_box_sequencer
//
// Directed bench for music_box_sequencer with TICKS_PER_BEAT=4, GAP_TICKS=2,
// SONG_LEN=4. Sample index i in a capture is the output value one time unit
// after the i-th rising edge following the edge that samples start.
// Per-note timeline from FETCH: FETCH, DECODE, ARM, PLAY x (beats*4), GAP x 2.
// -----------------------------------------------------------------------------
module tb_music_box_sequencer;

    localparam int SONG_LEN = 4;
    localparam int ADDR_W   = 2;
    localparam int TPB      = 4;
    localparam int GAPT     = 2;
    localparam int NCAP     = 100;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset   = 1'b0;
    logic start   = 1'b0;
    logic stop    = 1'b0;
    logic loop_en = 1'b0;

    logic [ADDR_W-1:0] rom_addr;
    logic [35:0]       rom_data;
    logic [31:0]       hz;
    logic              play_note;
    logic              note_reset;
    logic              busy;
    logic              done;
    logic [2:0]        state_dbg;

    always #5 clock = ~clock;

    music_box_sequencer #(
        .SONG_LEN      (SONG_LEN),
        .ADDR_W        (ADDR_W),
        .TICKS_PER_BEAT(TPB),
        .GAP_TICKS     (GAPT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .hz        (hz),
        .play_note (play_note),
        .note_reset(note_reset),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // Synchronous song ROM model: one cycle of read latency.
    logic [35:0] rom_mem [0:SONG_LEN-1];
    always @(posedge clock) rom_data <= rom_mem[rom_addr];

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    logic [31:0]       c_hz   [NCAP];
    logic              c_pn   [NCAP];
    logic              c_nr   [NCAP];
    logic              c_busy [NCAP];
    logic              c_done [NCAP];
    logic [ADDR_W-1:0] c_addr [NCAP];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load_rom(input logic [35:0] e0, input logic [35:0] e1,
                            input logic [35:0] e2, input logic [35:0] e3);
        rom_mem[0] = e0;
        rom_mem[1] = e1;
        rom_mem[2] = e2;
        rom_mem[3] = e3;
    endtask

    // Raise start for one edge and record n samples. loop_en is dropped right
    // after sample drop_loop_at (pass -1 to leave it alone).
    task automatic start_capture(input int n, input int drop_loop_at);
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            c_hz[i]   = hz;
            c_pn[i]   = play_note;
            c_nr[i]   = note_reset;
            c_busy[i] = busy;
            c_done[i] = done;
            c_addr[i] = rom_addr;
            if (i == drop_loop_at) loop_en = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [38:0] got;
        tick();
        tick();
        got = {hz, play_note, note_reset, busy, done, rom_addr, 1'b0};
        total++;
        if (got !== 39'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", got);
        end
        total++;
        if (state_dbg !== 3'd0) begin
            bad++;
            $display("FAIL reset_state got=%0d want=0", state_dbg);
        end
        @(negedge clock);
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({busy, done, play_note, note_reset} !== 4'b0000) begin
            bad++;
            $display("FAIL idle_after_release got=%b want=0000",
                     {busy, done, play_note, note_reset});
        end
    endtask

    task automatic test_basic;
        logic [3:0] got, want;
        load_rom({4'd2, 32'd1000}, {4'd1, 32'd2000}, 36'd0, 36'd0);
        loop_en = 1'b0;
        start_capture(30, -1);
        total++;
        if (c_addr[0] !== 2'd0) begin
            bad++;
            $display("FAIL basic_addr0 got=%0d want=0", c_addr[0]);
        end
        for (int i = 0; i < 30; i++) begin
            want[3] = ((i >= 3) && (i <= 10)) || ((i >= 16) && (i <= 19));
            want[2] = (i == 2) || (i == 15);
            want[1] = (i <= 23);
            want[0] = (i == 24);
            got = {c_pn[i], c_nr[i], c_busy[i], c_done[i]};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL basic_pn_nr_busy_done cyc=%0d got=%b want=%b", i, got, want);
            end
        end
        for (int i = 2; i <= 10; i++) begin
            total++;
            if (c_hz[i] !== 32'd1000) begin
                bad++;
                $display("FAIL basic_hz1 cyc=%0d got=%0d want=1000", i, c_hz[i]);
            end
        end
        for (int i = 15; i <= 19; i++) begin
            total++;
            if (c_hz[i] !== 32'd2000) begin
                bad++;
                $display("FAIL basic_hz2 cyc=%0d got=%0d want=2000", i, c_hz[i]);
            end
        end
    endtask

    task automatic test_rest;
        logic [3:0] got, want;
        load_rom({4'd1, 32'd0}, {4'd1, 32'd500}, 36'd0, 36'd0);
        start_capture(25, -1);
        for (int i = 0; i < 25; i++) begin
            want[3] = (i >= 12) && (i <= 15);
            want[2] = (i == 11);
            want[1] = (i <= 19);
            want[0] = (i == 20);
            got = {c_pn[i], c_nr[i], c_busy[i], c_done[i]};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL rest_pn_nr_busy_done cyc=%0d got=%b want=%b", i, got, want);
            end
        end
        total++;
        if (c_hz[4] !== 32'd0) begin
            bad++;
            $display("FAIL rest_hz got=%0d want=0", c_hz[4]);
        end
        total++;
        if (c_hz[13] !== 32'd500) begin
            bad++;
            $display("FAIL rest_note_hz got=%0d want=500", c_hz[13]);
        end
    endtask

    task automatic test_full_song;
        logic [3:0] got, want;
        int r;
        load_rom({4'd1, 32'd100}, {4'd1, 32'd200}, {4'd1, 32'd300}, {4'd1, 32'd400});
        loop_en = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'd100);
        exp_q.push_back(32'd200);
        exp_q.push_back(32'd300);
        exp_q.push_back(32'd400);
        start_capture(40, -1);
        for (int i = 0; i < 40; i++) begin
            r = i % 9;
            want[3] = (i < 36) && (r >= 3) && (r <= 6);
            want[2] = (i < 36) && (r == 2);
            want[1] = (i < 36);
            want[0] = (i == 36);
            got = {c_pn[i], c_nr[i], c_busy[i], c_done[i]};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL full_pn_nr_busy_done cyc=%0d got=%b want=%b", i, got, want);
            end
            if (c_nr[i] === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL full_extra_note cyc=%0d got_hz=%0d want=none", i, c_hz[i]);
                end else if (c_hz[i] !== exp_q[0]) begin
                    bad++;
                    $display("FAIL full_note_hz cyc=%0d got=%0d want=%0d", i, c_hz[i], exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL full_missing_notes got_left=%0d want=0", exp_q.size());
        end
        for (int i = 36; i < 40; i++) begin
            total++;
            if (c_addr[i] !== 2'd3) begin
                bad++;
                $display("FAIL full_addr_hold cyc=%0d got=%0d want=3", i, c_addr[i]);
            end
        end
    endtask

    task automatic test_loop;
        logic [3:0] got, want;
        int r;
        load_rom({4'd1, 32'd700}, {4'd1, 32'd800}, 36'd0, 36'd0);
        loop_en = 1'b1;
        start_capture(85, 65);
        for (int i = 0; i < 85; i++) begin
            r = i % 20;
            want[3] = (i < 80) && (((r >= 3) && (r <= 6)) || ((r >= 12) && (r <= 15)));
            want[2] = (i < 80) && ((r == 2) || (r == 11));
            want[1] = (i < 80);
            want[0] = (i == 80);
            got = {c_pn[i], c_nr[i], c_busy[i], c_done[i]};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL loop_pn_nr_busy_done cyc=%0d got=%b want=%b", i, got, want);
            end
        end
        for (int p = 0; p < 4; p++) begin
            total++;
            if (c_addr[p*20] !== 2'd0) begin
                bad++;
                $display("FAIL loop_addr_restart pass=%0d got=%0d want=0", p, c_addr[p*20]);
            end
            total++;
            if (c_hz[p*20+3] !== 32'd700) begin
                bad++;
                $display("FAIL loop_first_hz pass=%0d got=%0d want=700", p, c_hz[p*20+3]);
            end
        end
    endtask

    task automatic test_stop;
        load_rom({4'd2, 32'd1000}, {4'd1, 32'd2000}, 36'd0, 36'd0);
        loop_en = 1'b0;
        start = 1'b1;
        tick();                       // i=0 FETCH
        start = 1'b0;
        for (int i = 1; i <= 5; i++) tick();   // i=5: third PLAY cycle
        total++;
        if (play_note !== 1'b1) begin
            bad++;
            $display("FAIL stop_pre_play got=%b want=1", play_note);
        end
        stop = 1'b1;
        tick();
        total++;
        if ({play_note, note_reset, busy, done} !== 4'b0000) begin
            bad++;
            $display("FAIL stop_outputs got=%b want=0000", {play_note, note_reset, busy, done});
        end
        total++;
        if ((hz !== 32'd1000) || (rom_addr !== 2'd0)) begin
            bad++;
            $display("FAIL stop_hold got_hz=%0d got_addr=%0d want_hz=1000 want_addr=0", hz, rom_addr);
        end
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ((busy !== 1'b0) || (done !== 1'b0)) begin
                bad++;
                $display("FAIL stop_blocks_start cyc=%0d got_busy=%b got_done=%b want=0", i, busy, done);
            end
        end
        stop = 1'b0;
        tick();
        start = 1'b0;
        total++;
        if ((busy !== 1'b1) || (rom_addr !== 2'd0)) begin
            bad++;
            $display("FAIL stop_restart got_busy=%b got_addr=%0d want_busy=1 want_addr=0", busy, rom_addr);
        end
        tick();
        tick();
        total++;
        if ((note_reset !== 1'b1) || (hz !== 32'd1000) || (play_note !== 1'b0)) begin
            bad++;
            $display("FAIL stop_restart_arm got_nr=%b got_hz=%0d got_pn=%b want=1/1000/0",
                     note_reset, hz, play_note);
        end
        tick();
        total++;
        if (play_note !== 1'b1) begin
            bad++;
            $display("FAIL stop_restart_play got=%b want=1", play_note);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL stop_second got_busy=%b want=0", busy);
        end
    endtask

    task automatic test_reset_mid_note;
        logic [38:0] got;
        load_rom({4'd2, 32'd1000}, {4'd1, 32'd2000}, 36'd0, 36'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) tick();   // i=4: in PLAY
        total++;
        if ((play_note !== 1'b1) || (hz !== 32'd1000)) begin
            bad++;
            $display("FAIL rstmid_pre got_pn=%b got_hz=%0d want=1/1000", play_note, hz);
        end
        #2;
        reset = 1'b0;
        #1;
        got = {hz, play_note, note_reset, busy, done, rom_addr, 1'b0};
        total++;
        if (got !== 39'd0) begin
            bad++;
            $display("FAIL rstmid_async got=%h want=0", got);
        end
        total++;
        if (state_dbg !== 3'd0) begin
            bad++;
            $display("FAIL rstmid_state got=%0d want=0", state_dbg);
        end
        @(negedge clock);
        reset = 1'b1;
        tick();
        test_basic();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_rest();
        test_full_song();
        test_loop();
        test_stop();
        test_reset_mid_note();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/music_box_sequencer.md
# music_box_sequencer

Note sequencer that plays a stored melody through the square-wave tone generator. It fetches note entries (tone period plus duration in beats) from an external synchronous song ROM one at a time. For each note it drives the generator's `hz`, `play_note` and phase-reset inputs, holds the note for the programmed number of beats, then inserts a fixed silent gap. It sits between the user controls (start/stop/loop switches) and the tone generator feeding the audio codec path.

## Interface
- `SONG_LEN`, 16: number of ROM entries; addresses 0..SONG_LEN-1.
- `ADDR_W`, 4: ROM address width; must satisfy 2^ADDR_W >= SONG_LEN.
- `TICKS_PER_BEAT`, 12500000: clock cycles per beat (250 ms at 50 MHz); >= 1.
- `GAP_TICKS`, 500000: silent cycles between notes; >= 1.

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: level; begins playback from entry 0 when sampled high in IDLE.
- `stop` in 1: level; aborts playback; has priority over `start`.
- `loop_en` in 1: at end of song, restart at entry 0 instead of finishing.
- `rom_addr` out ADDR_W: song ROM address.
- `rom_data` in 36: valid one cycle after `rom_addr` changes. Bits [35:32] = beats, where 0 means end-of-song marker. Bits [31:0] = period, where 0 means rest.
- `hz` out 32: period to the tone generator.
- `play_note` out 1: tone enable.
- `note_reset` out 1: one-cycle active-high pulse that resynchronises the generator phase.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on natural song completion.

## Operation
- States: IDLE, FETCH, DECODE, ARM, PLAY, GAP.
- All outputs are registered.
- Reset values: `rom_addr`=0, `hz`=0, `play_note`=0, `note_reset`=0, `busy`=0, `done`=0; state=IDLE; all counters=0.
- **IDLE:** if `start` is high and `stop` is low, set `rom_addr`<=0 and go to FETCH. `start` is ignored in every other state.
- **FETCH:** one wait cycle for the ROM, then go to DECODE.
- **DECODE:** sample `rom_data`.
  - If beats==0 (end of song): with `loop_en` high, set `rom_addr`<=0 and go to FETCH. Otherwise pulse `done` and go to IDLE.
  - Otherwise, load `beat_cnt`<=beats and `tick_cnt`<=0, then go to ARM.
    - Note (period!=0): set `hz`<=period and pulse `note_reset` for the ARM cycle.
    - Rest (period==0): set `hz`<=0; no `note_reset` pulse.
- **ARM:** one cycle. `play_note`<=(hz!=0), then go to PLAY.
- **PLAY:** `tick_cnt` counts 0..TICKS_PER_BEAT-1 and wraps, decrementing `beat_cnt` on each wrap. On the wrap where `beat_cnt`==1, drop `play_note`, set `gap_cnt`<=0 and go to GAP.
- **GAP:** count GAP_TICKS cycles.
  - If `rom_addr`==SONG_LEN-1, apply the end-of-song rule (loop or `done`/IDLE) directly.
  - Otherwise, set `rom_addr`<=`rom_addr`+1 and go to FETCH.
- **stop:** when sampled high in any non-IDLE state, the next state is IDLE. `play_note`, `note_reset` and `busy` clear on that edge. No `done` pulse. `hz` and `rom_addr` hold their values.
- **Asynchronous reset mid-note:** immediate return to reset values.
- `loop_en` is sampled only at end-of-song decisions.
- Counter widths must hold TICKS_PER_BEAT-1 and GAP_TICKS-1 without overflow.

## Timing
- `start` sampled at edge k gives:
  - `rom_addr`=0 valid after k.
  - DECODE after k+1.
  - `hz` valid and `note_reset`=1 after k+2.
  - `play_note`=1 after k+3.
- `play_note` stays high for exactly beats*TICKS_PER_BEAT cycles.
- Silence between consecutive notes = GAP_TICKS + 3 cycles: the gap plus FETCH, DECODE and ARM.
- `note_reset` is high only during ARM, never in the same cycle as `play_note`.
- `done` is asserted for exactly one cycle, concurrent with the first IDLE cycle.
- `stop` takes effect on the outputs one edge after it is sampled.

## Test plan
Bench parameters: TICKS_PER_BEAT=4, GAP_TICKS=2, SONG_LEN=4.

- **Basic playback.** ROM = {(2,1000),(1,2000),(0,x),...}. Pulse `start`.
  - `note_reset` pulse, then `hz`=1000 with `play_note` high for 8 cycles.
  - 5 silent cycles, then `hz`=2000 with `play_note` high for 4 cycles.
  - `done` pulses once; `busy` falls.
- **Rest entry.** ROM = {(1,0),(1,500),(0,x)}.
  - The first 4-cycle PLAY window has `play_note`=0 and no `note_reset`.
  - The second plays 500 for 4 cycles.
- **Full song, no marker, `loop_en`=0.** All 4 entries have beats=1.
  - After address 3's gap, `done` pulses and `rom_addr` holds 3.
- **Loop.** `loop_en`=1 with a 2-note song.
  - `rom_addr` returns to 0 and playback repeats 3 times with no `done` pulse.
  - Dropping `loop_en` lets the song finish and pulse `done`.
- **Stop mid-note.** `stop` asserted in the 3rd PLAY cycle.
  - One edge later: `play_note`=0, `busy`=0, no `done`.
  - `start` while `stop` is high is ignored; after `stop` falls, `start` restarts at entry 0.
- **Reset mid-note.** `reset` driven low asynchronously during PLAY.
  - All outputs go to reset values immediately.
  - `start` after release behaves as in the basic playback scenario.
